otter_cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER RV32I core. It sits beside the control-unit decoder and sequences each instruction through fetch, execute, writeback and interrupt cycles. From opcode/func3 it generates the write and read enables for the PC, register file, memory and CSR file. It also generates int_taken, which the decoder consumes to force the PC source to the trap vector and the register-file write select to the CSR path.

---
 rtl/otter_cu_fsm_pkg.sv | 28 ++
 rtl/otter_cu_fsm_if.sv | 27 ++
 rtl/otter_cu_fsm.sv | 112 +++++++++++
 tb/tb_otter_cu_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_fsm_pkg.sv
// Shared types for the OTTER multicycle control unit: opcodes, func3 constants, FSM states.
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control bundle between the instruction/decoder side (master) and the CU FSM (slave).
interface otter_cu_fsm_if;
  logic       intr;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       pcWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       rst_out;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  modport master (
    output intr, opcode, func3,
    input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           rst_out, csr_WE, int_taken, mret_exec
  );

  modport slave (
    input  intr, opcode, func3,
    output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           rst_out, csr_WE, int_taken, mret_exec
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR] -> FETCH.
// Interrupt handling is built only when OTTER_CU_FSM_INTR_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  otter_cu_fsm_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  cu_state_t        r_state;
  cu_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_intr;

  // Final cycle of a memory-latency-held state (FETCH or WB)
  assign w_last = (r_cnt == CNT_W'(MEM_LAT - 1));

`ifdef OTTER_CU_FSM_INTR_EN
  assign w_intr = bus.intr;
`else
  logic w_unused_intr;
  assign w_unused_intr = bus.intr;
  assign w_intr        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FETCH || r_state == ST_WB) && !w_last)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.pcWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memWE2    = 1'b0;
    bus.memRDEN1  = 1'b0;
    bus.memRDEN2  = 1'b0;
    bus.rst_out   = 1'b0;
    bus.csr_WE    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;

    case (r_state)
      ST_INIT: begin
        bus.rst_out = 1'b1;
        w_next      = ST_FETCH;
      end

      ST_FETCH: begin
        bus.memRDEN1 = 1'b1;
        if (w_last) w_next = ST_EXEC;
      end

      ST_EXEC: begin
        if (bus.opcode == LOAD) begin
          bus.memRDEN2 = 1'b1;
          w_next       = ST_WB;
        end else begin
          // Every non-load retires here; unknown opcodes behave as NOPs
          bus.pcWrite = 1'b1;
          w_next      = w_intr ? ST_INTR : ST_FETCH;
          case (bus.opcode)
            STORE: bus.memWE2 = 1'b1;
            SYS: begin
              if (bus.func3 == F3_CSRRW) begin
                bus.csr_WE   = 1'b1;
                bus.regWrite = 1'b1;
              end else if (bus.func3 == F3_MRET) begin
                bus.mret_exec = 1'b1;
              end
            end
            LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: bus.regWrite = 1'b1;
            default: ;
          endcase
        end
      end

      ST_WB: begin
        bus.memRDEN2 = 1'b1;
        if (w_last) begin
          bus.regWrite = 1'b1;
          bus.pcWrite  = 1'b1;
          w_next       = w_intr ? ST_INTR : ST_FETCH;
        end
      end

      ST_INTR: begin
        // intr deliberately ignored here so traps cannot chain
        bus.int_taken = 1'b1;
        bus.pcWrite   = 1'b1;
        w_next        = ST_FETCH;
      end

      default: w_next = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: MEM_LAT=1 and MEM_LAT=3 instances share one stimulus stream.
module tb_otter_cu_fsm;

  localparam logic [8:0] PC = 9'h100, RW = 9'h080, WE = 9'h040, R1 = 9'h020, R2 = 9'h010,
                         RS = 9'h008, CS = 9'h004, IT = 9'h002, MR = 9'h001;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_IMM = 7'b0010011, O_OP = 7'b0110011,
                         O_SYS = 7'b1110011, O_BAD = 7'b1111111;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       intr = 1'b0;
  logic [6:0] opc = O_IMM;
  logic [2:0] f3 = 3'b000;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 CLK = ~CLK;

  otter_cu_fsm_if b1 ();
  otter_cu_fsm_if b3 ();

  assign b1.intr = intr;  assign b1.opcode = opc;  assign b1.func3 = f3;
  assign b3.intr = intr;  assign b3.opcode = opc;  assign b3.func3 = f3;

  otter_cu_fsm #(.MEM_LAT(1)) u_dut1 (.CLK(CLK), .RST(rst), .bus(b1));
  otter_cu_fsm #(.MEM_LAT(3)) u_dut3 (.CLK(CLK), .RST(rst), .bus(b3));

  function automatic logic [8:0] obs(input int lat);
    if (lat == 1)
      return {b1.pcWrite, b1.regWrite, b1.memWE2, b1.memRDEN1, b1.memRDEN2,
              b1.rst_out, b1.csr_WE, b1.int_taken, b1.mret_exec};
    return {b3.pcWrite, b3.regWrite, b3.memWE2, b3.memRDEN1, b3.memRDEN2,
            b3.rst_out, b3.csr_WE, b3.int_taken, b3.mret_exec};
  endfunction

  // New inputs land 2 time units after the edge; outputs are sampled 1 unit later.
  task automatic drive(input logic r, input logic i, input logic [6:0] o, input logic [2:0] f);
    @(posedge CLK);
    #2;
    rst = r; intr = i; opc = o; f3 = f;
  endtask

  task automatic enter_reset();
    drive(1'b1, 1'b0, O_IMM, 3'b000);
    drive(1'b1, 1'b0, O_IMM, 3'b000);
  endtask

  task automatic test_reset();
    logic [8:0] ex [3] = '{RS, R1, PC | RW};
    enter_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, O_IMM, 3'b000);
      #1;
      n_chk++;
      if (obs(1) !== ex[i]) begin
        n_fail++;
        $display("FAIL reset row %0d: got %b want %b", i, obs(1), ex[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [8] = '{O_IMM, O_LUI, O_AUIPC, O_JAL, O_JALR, O_OP, O_BR, O_BAD};
    logic [8:0] ex  [8] = '{PC|RW, PC|RW, PC|RW, PC|RW, PC|RW, PC|RW, PC, PC};
    enter_reset();
    drive(1'b0, 1'b0, O_IMM, 3'b000);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, ops[k], 3'b000);
      #1;
      n_chk++;
      if (obs(1) !== R1) begin
        n_fail++;
        $display("FAIL alu_fetch op %b: got %b want %b", ops[k], obs(1), R1);
      end
      drive(1'b0, 1'b0, ops[k], 3'b000);
      #1;
      n_chk++;
      if (obs(1) !== ex[k]) begin
        n_fail++;
        $display("FAIL alu_exec op %b: got %b want %b", ops[k], obs(1), ex[k]);
      end
    end
  endtask

  task automatic test_load_lat3();
    logic [8:0] ex [10] = '{RS, R1, R1, R1, R2, R2, R2, R2|RW|PC, R1, R1};
    enter_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, O_LD, 3'b010);
      #1;
      n_chk++;
      if (obs(3) !== ex[i]) begin
        n_fail++;
        $display("FAIL load_lat3 row %0d: got %b want %b", i, obs(3), ex[i]);
      end
    end
  endtask

  task automatic test_store_intr();
    logic       in [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef OTTER_CU_FSM_INTR_EN
    logic [8:0] ex [7] = '{RS, R1, WE|PC, IT|PC, R1, WE|PC, R1};
`else
    logic [8:0] ex [7] = '{RS, R1, WE|PC, R1, WE|PC, R1, WE|PC};
`endif
    enter_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, in[i], O_ST, 3'b010);
      #1;
      n_chk++;
      if (obs(1) !== ex[i]) begin
        n_fail++;
        $display("FAIL store_intr row %0d: got %b want %b", i, obs(1), ex[i]);
      end
    end
  endtask

  task automatic test_sys();
    logic [2:0] fs [11] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010,
                            3'b000, 3'b000, 3'b000, 3'b000};
    logic       in [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1, 1'b0};
`ifdef OTTER_CU_FSM_INTR_EN
    logic [8:0] ex [11] = '{RS, R1, CS|RW|PC, R1, MR|PC, R1, PC, R1, MR|PC, IT|PC, R1};
`else
    logic [8:0] ex [11] = '{RS, R1, CS|RW|PC, R1, MR|PC, R1, PC, R1, MR|PC, R1, MR|PC};
`endif
    enter_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, in[i], O_SYS, fs[i]);
      #1;
      n_chk++;
      if (obs(1) !== ex[i]) begin
        n_fail++;
        $display("FAIL sys row %0d: got %b want %b", i, obs(1), ex[i]);
      end
    end
  endtask

  // Pulses on a FETCH cycle and a non-final WB cycle are lost; one on the final WB cycle is taken.
  task automatic test_wb_intr();
    logic       in [19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef OTTER_CU_FSM_INTR_EN
    logic [8:0] ex [19] = '{RS, R1, R1, R1, R2, R2, R2, R2|RW|PC, R1, R1, R1, R2, R2, R2,
                            R2|RW|PC, IT|PC, R1, R1, R1};
`else
    logic [8:0] ex [19] = '{RS, R1, R1, R1, R2, R2, R2, R2|RW|PC, R1, R1, R1, R2, R2, R2,
                            R2|RW|PC, R1, R1, R1, R2};
`endif
    enter_reset();
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, in[i], O_LD, 3'b010);
      #1;
      n_chk++;
      if (obs(3) !== ex[i]) begin
        n_fail++;
        $display("FAIL wb_intr row %0d: got %b want %b", i, obs(3), ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wb(input logic hold_intr);
    logic       rs [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [8:0] ex [10] = '{RS, R1, R1, R1, R2, R2, R2, RS, R1, R1};
    enter_reset();
    for (int i = 0; i < 10; i++) begin
      drive(rs[i], hold_intr, O_LD, 3'b010);
      #1;
      n_chk++;
      if (obs(3) !== ex[i]) begin
        n_fail++;
        $display("FAIL reset_mid_wb intr=%0b row %0d: got %b want %b", hold_intr, i, obs(3), ex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_lat3();
    test_store_intr();
    test_sys();
    test_wb_intr();
    test_reset_mid_wb(1'b0);
    test_reset_mid_wb(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
